// File: rtl/microseq_ctrl_if.sv
// Run-control and configuration bus for microseq_ctrl.
// The slave modport is the sequencer side, the master modport is the host side.
interface microseq_ctrl_if #(
  parameter int SW = 4,
  parameter int ZW = 2,
  parameter int CW = 8
);
  logic          start;
  logic [ZW-1:0] z;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [SW-1:0] cfg_addr;
  logic [SW-1:0] cfg_data;
  logic          busy;
  logic          done;
  logic [SW-1:0] state;
  logic [CW-1:0] step_cnt;
  logic          err;

  modport slave (
    input  start, z, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output busy, done, state, step_cnt, err
  );

  modport master (
    output start, z, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  busy, done, state, step_cnt, err
  );
endinterface

// File: rtl/microseq_ctrl.sv
// Microcoded run-control sequencer: one program pass per accepted start, with
// writable microcode and dispatch tables and a sticky fault flag.
module microseq_ctrl #(
  parameter int NSTATES = 13,
  parameter int SW      = 4,
  parameter int ZW      = 2,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  microseq_ctrl_if.slave   bus_if
);

  typedef enum logic {
    IDLE_S = 1'b0,
    RUN_S  = 1'b1
  } ctrl_e;

  localparam int            NDISP    = 1 << ZW;
  localparam logic [SW-1:0] NST_SW   = SW'(NSTATES);
  localparam logic [SW-1:0] NDISP_SW = SW'(NDISP);
  localparam logic [SW-1:0] ONE_SW   = SW'(1'b1);
  localparam logic [SW-1:0] JUMP7_SW = SW'(4'd7);
  localparam logic [CW-1:0] STEP_MAX = {CW{1'b1}};

  function automatic logic [2:0] ucode_default(input int idx);
    case (idx)
      3:       return 3'd1;
      4, 5:    return 3'd2;
      10:      return 3'd3;
      11, 12:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [SW-1:0] disp1_default(input int idx);
    case (idx)
      0:       return SW'(4'd4);
      1:       return SW'(4'd5);
      default: return SW'(4'd6);
    endcase
  endfunction

  function automatic logic [SW-1:0] disp2_default(input int idx);
    case (idx)
      0:       return SW'(4'd11);
      default: return SW'(4'd12);
    endcase
  endfunction

  ctrl_e         ctrl_q, ctrl_d;
  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [2:0]    ucode_q [NSTATES];
  logic [SW-1:0] disp1_q [NDISP];
  logic [SW-1:0] disp2_q [NDISP];

  logic [2:0]    act_s;
  logic          fault_s;
  logic          cfg_wr_s;
  logic          ucode_addr_ok_s;
  logic          disp_addr_ok_s;

  // Current action; an out-of-range state reads as an illegal code so both faults share one path.
  always_comb begin
    act_s = 3'd7;
    if (state_q < NST_SW) begin
      act_s = ucode_q[state_q];
    end else begin
      act_s = 3'd7;
    end
    fault_s = (act_s > 3'd4);
  end

  // Controller next-state and datapath updates.
  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (ctrl_q)
      IDLE_S: begin
        if (bus_if.start && !bus_if.cfg_we) begin
          ctrl_d  = RUN_S;
          state_d = '0;
          step_d  = '0;
          err_d   = 1'b0;
        end else begin
          ctrl_d  = IDLE_S;
        end
      end
      RUN_S: begin
        if (fault_s) begin
          ctrl_d  = IDLE_S;
          state_d = '0;
          err_d   = 1'b1;
        end else begin
          step_d = (step_q == STEP_MAX) ? step_q : step_q + CW'(1'b1);
          case (act_s)
            3'd0:    state_d = state_q + ONE_SW;
            3'd1:    state_d = disp1_q[bus_if.z];
            3'd2:    state_d = JUMP7_SW;
            3'd3:    state_d = disp2_q[bus_if.z];
            3'd4: begin
              state_d = '0;
              ctrl_d  = IDLE_S;
              done_d  = 1'b1;
            end
            default: state_d = '0;
          endcase
        end
      end
      default: begin
        ctrl_d  = IDLE_S;
        state_d = '0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= IDLE_S;
      state_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Config strobe qualification; writes land only while idle and in range.
  always_comb begin
    cfg_wr_s        = bus_if.cfg_we && (ctrl_q == IDLE_S);
    ucode_addr_ok_s = (bus_if.cfg_addr < NST_SW);
    disp_addr_ok_s  = (bus_if.cfg_addr < NDISP_SW);
  end

  // Microcode and dispatch tables, reloaded with the default program on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTATES; i++) ucode_q[i] <= ucode_default(i);
      for (int i = 0; i < NDISP; i++) begin
        disp1_q[i] <= disp1_default(i);
        disp2_q[i] <= disp2_default(i);
      end
    end else if (cfg_wr_s) begin
      case (bus_if.cfg_sel)
        2'd0: if (ucode_addr_ok_s) ucode_q[bus_if.cfg_addr] <= bus_if.cfg_data[2:0];
        2'd1: if (disp_addr_ok_s) disp1_q[bus_if.cfg_addr[ZW-1:0]] <= bus_if.cfg_data;
        2'd2: if (disp_addr_ok_s) disp2_q[bus_if.cfg_addr[ZW-1:0]] <= bus_if.cfg_data;
        default: ;
      endcase
    end
  end

  assign bus_if.busy     = (ctrl_q == RUN_S);
  assign bus_if.done     = done_q;
  assign bus_if.state    = state_q;
  assign bus_if.step_cnt = step_q;
  assign bus_if.err      = err_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl: default program passes, table writes, faults,
// back-to-back restart and mid-pass reset.
module tb_microseq_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  microseq_ctrl_if #(.SW(4), .ZW(2), .CW(8)) bus ();

  microseq_ctrl #(.NSTATES(13), .SW(4), .ZW(2), .CW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] trace[$];
  logic [3:0] exp_t[$];
  int         busy_cyc;
  int         done_cnt;
  logic [7:0] last_step;
  logic       last_err;
  logic       err_first;
  logic       timeout;
  logic       bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic [3:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  // Pulses start and records the state trace until busy falls, bounded.
  task automatic do_pass(input logic [1:0] zv);
    trace.delete();
    busy_cyc = 0;
    done_cnt = 0;
    bus.z     = zv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    err_first = bus.err;
    for (int i = 0; i < 40; i++) begin
      trace.push_back(bus.state);
      if (bus.done) done_cnt++;
      if (!bus.busy) break;
      busy_cyc++;
      tick();
    end
    timeout   = bus.busy;
    last_step = bus.step_cnt;
    last_err  = bus.err;
    tick();
    if (bus.done) done_cnt++;
  endtask

  task automatic check_trace(input string name);
    checks++;
    bad = (trace.size() != exp_t.size()) || timeout;
    foreach (exp_t[i]) if (i < trace.size() && trace[i] !== exp_t[i]) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL %s trace got=%p expected=%p timeout=%0b", name, trace, exp_t, timeout);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b expected=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b expected=0", bus.done); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b expected=0", bus.err); end
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d expected=0", bus.state); end
    checks++;
    if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL reset_step got=%0d expected=0", bus.step_cnt); end
  endtask

  task automatic test_default_passes();
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("z0");
    checks++;
    if (busy_cyc != 10) begin errors++; $display("FAIL z0_busy_cycles got=%0d expected=10", busy_cyc); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL z0_done_pulses got=%0d expected=1", done_cnt); end
    checks++;
    if (last_step !== 8'd10) begin errors++; $display("FAIL z0_step got=%0d expected=10", last_step); end
    checks++;
    if (bus.step_cnt !== 8'd10) begin errors++; $display("FAIL z0_step_hold got=%0d expected=10", bus.step_cnt); end

    do_pass(2'd1);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd0};
    check_trace("z1");
    checks++;
    if (last_step !== 8'd10) begin errors++; $display("FAIL z1_step got=%0d expected=10", last_step); end

    do_pass(2'd2);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd0};
    check_trace("z2");
  endtask

  task automatic test_dispatch_write();
    cfg_write(2'd1, 4'd0, 4'd9);
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("disp1_write");
    checks++;
    if (last_step !== 8'd7) begin errors++; $display("FAIL disp1_step got=%0d expected=7", last_step); end

    // Write attempted during a pass, then a null-target write and an out-of-range address.
    bus.z     = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'd1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 4'd4;
    tick(); tick(); tick();
    bus.cfg_we = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    cfg_write(2'd3, 4'd0, 4'd4);
    cfg_write(2'd1, 4'd4, 4'd4);
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("ignored_writes");
  endtask

  task automatic test_start_with_write();
    bus.start    = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'd1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 4'd4;
    tick();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_with_write_busy got=%0b expected=0", bus.busy); end
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("write_won");
  endtask

  task automatic test_fault_ucode();
    cfg_write(2'd0, 4'd1, 4'd5);
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd0};
    check_trace("ucode_fault");
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL ucode_fault_err got=%0b expected=1", last_err); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL ucode_fault_done got=%0d expected=0", done_cnt); end
    checks++;
    if (last_step !== 8'd1) begin errors++; $display("FAIL ucode_fault_step got=%0d expected=1", last_step); end
    cfg_write(2'd0, 4'd1, 4'd0);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b expected=1", bus.err); end
    do_pass(2'd0);
    checks++;
    if (err_first !== 1'b0) begin errors++; $display("FAIL err_cleared_by_start got=%0b expected=0", err_first); end
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("after_ucode_fix");
  endtask

  task automatic test_fault_dispatch();
    cfg_write(2'd2, 4'd0, 4'd14);
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd14, 4'd0};
    check_trace("disp2_fault");
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL disp2_fault_err got=%0b expected=1", last_err); end
    checks++;
    if (last_step !== 8'd9) begin errors++; $display("FAIL disp2_fault_step got=%0d expected=9", last_step); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL disp2_fault_done got=%0d expected=0", done_cnt); end
    cfg_write(2'd2, 4'd0, 4'd11);
  endtask

  task automatic test_back_to_back();
    int cyc1;
    int cyc2;
    int dn2;
    bus.z     = 2'd0;
    bus.start = 1'b1;
    tick();
    cyc1 = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin cyc1++; tick(); end
    checks++;
    if (cyc1 != 10) begin errors++; $display("FAIL b2b_first_busy got=%0d expected=10", cyc1); end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done_cycle got done=%0b busy=%0b expected done=1 busy=0", bus.done, bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.state !== 4'd0 || bus.step_cnt !== 8'd0) begin
      errors++; $display("FAIL b2b_restart got busy=%0b state=%0d step=%0d expected 1/0/0", bus.busy, bus.state, bus.step_cnt);
    end
    bus.start = 1'b0;
    cyc2 = 0;
    dn2  = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin cyc2++; tick(); end
    if (bus.done) dn2++;
    tick();
    if (bus.done) dn2++;
    checks++;
    if (cyc2 != 10 || dn2 != 1) begin errors++; $display("FAIL b2b_second got busy=%0d done=%0d expected 10/1", cyc2, dn2); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue got busy=%0b expected=0", bus.busy); end
  endtask

  task automatic test_reset_mid_pass();
    cfg_write(2'd1, 4'd3, 4'd9);
    cfg_write(2'd2, 4'd3, 4'd14);
    bus.z     = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.state != 4'd8; i++) tick();
    checks++;
    if (bus.state !== 4'd8 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reach_state8 got state=%0d busy=%0b expected 8/1", bus.state, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.state !== 4'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%0b state=%0d done=%0b expected 0/0/0", bus.busy, bus.state, bus.done);
    end
    #2;
    rst_n = 1'b1;
    tick();
    do_pass(2'd3);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd0};
    check_trace("defaults_z3");
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL defaults_z3_err got=%0b expected=0", last_err); end
    do_pass(2'd0);
    exp_t = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    check_trace("defaults_z0");
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.z        = 2'd0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 2'd3;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 4'd0;
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_default_passes();
    test_dispatch_write();
    test_start_with_write();
    test_fault_ucode();
    test_fault_dispatch();
    test_back_to_back();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
- Run-control sequencer for the team's microcoded control FSM.
- Owns the state register, a writable microcode table and two writable dispatch tables.
- A start/busy/done handshake runs one pass of the microprogram from state 0 back to state 0.
- A configuration port reprograms the tables while idle; illegal microcode or out-of-range states raise a sticky error.

Parameters:
NSTATES, 13, number of valid microcode states (addresses 0..NSTATES-1)
SW, 4, state register width
ZW, 2, dispatch select width (each dispatch table has 2^ZW entries)
CW, 8, step counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request one program pass; accepted only when busy=0
z  input  ZW  dispatch select, sampled at every RUN edge
cfg_we  input  1  table write strobe; honoured only when busy=0
cfg_sel  input  2  target table: 0 microcode, 1 dispatch1, 2 dispatch2, 3 none
cfg_addr  input  SW  table entry index
cfg_data  input  SW  write data; microcode uses bits [2:0]
busy  output  1  program pass in progress
done  output  1  one-cycle pulse on normal completion
state  output  SW  current microcode state
step_cnt  output  CW  transitions taken in current/last pass, saturating
err  output  1  sticky fault flag

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, err=0, state=0, step_cnt=0.
  - Tables reload defaults: microcode[0..12] = 0,0,0,1,2,2,0,0,0,0,3,4,4; dispatch1[0..3] = 4,5,6,6; dispatch2[0..3] = 11,12,12,12.
  - Reset mid-pass aborts the pass with no done pulse.
- Controller states: IDLE (busy=0) and RUN (busy=1).
- IDLE:
  - start=1 and cfg_we=0 → next edge: busy=1, state=0, step_cnt=0, err=0.
  - start=1 and cfg_we=1 in the same cycle: the write wins and start is ignored.
- RUN, every edge, the action is a=microcode[state]:
  - a=0: state+1.
  - a=1: dispatch1[z].
  - a=2: 7.
  - a=3: dispatch2[z].
  - a=4: return. state=0, busy=0, done=1.
  - step_cnt increments on each of these edges, including the return edge, and saturates at 2^CW-1.
- Fault in RUN: if a is 5..7, or state >= NSTATES when the edge arrives, then err=1, busy=0, state=0, done stays 0, step_cnt holds.
  - A dispatch target >= NSTATES is therefore caught one edge later.
- done:
  - Registered; high exactly one cycle after the return edge.
  - A start in that cycle is accepted, since busy=0.
- Config writes:
  - Take effect at the edge when cfg_we=1 and busy=0.
  - Ignored when busy=1, when cfg_sel=3, or when the address is out of range (microcode addr >= NSTATES; dispatch addr >= 2^ZW).
  - A write is visible to the next pass.
- start while busy=1 is ignored; no queuing.
- err holds until the next accepted start or reset. err does not block config writes.
- Table lookups are combinational from state and z; next-state latency is one clock.

Test Plan:
- Reset, start pulse, z=0 held: state sequence 0,1,2,3,4,7,8,9,10,11,0; busy high 10 cycles; done pulses once; step_cnt=10.
- z=1 held: states 0,1,2,3,5,7,8,9,10,12,0; step_cnt=10. z=2: 0,1,2,3,6,7,8,9,10,12,0.
- Idle write cfg_sel=1, addr=0, data=9; run with z=0: 3→9→10→11→0; step_cnt=7. Write attempted while busy is ignored; the table readback pass is unchanged.
- Write microcode[1]=5 while idle; start: at state 1, err=1, busy=0, state=0, no done. Next start clears err.
- Write dispatch2[0]=14; run with z=0: 10→14 then err=1. start held high for the whole pass: exactly one pass, and restart occurs in the done cycle.
- Assert rst_n=0 at state 8: immediately busy=0 and state=0. The earlier modified table entries read back at their defaults on the next pass (z=0 sequence matches scenario 1).
